// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Defines shared by the core-side data-memory model and its test harness.
//   - Opcode and funct3 constants for the load/store path.
//   - MMIO base address and register offsets.
//   - The address region type and the address decode helper.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    // Opcode / funct3 constants used by the load/store path.
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [2:0] FUNCT3_B   = 3'b000;
    localparam logic [2:0] FUNCT3_H   = 3'b001;
    localparam logic [2:0] FUNCT3_W   = 3'b010;

    // MMIO register block.
    localparam logic [31:0] MMIO_BASE     = 32'h8000_0000;
    localparam logic [31:0] OFF_TOHOST    = 32'h0000_0000;
    localparam logic [31:0] OFF_CYCLE     = 32'h0000_0004;
    localparam logic [31:0] OFF_CONS_DATA = 32'h0000_0008;
    localparam logic [31:0] OFF_CONS_STAT = 32'h0000_000C;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_TOHOST,
        REG_CYCLE,
        REG_CONS_DATA,
        REG_CONS_STAT
    } region_t;

    // ram_aw is log2 of the RAM size in words. Bits [1:0] never take part.
    function automatic region_t decode_addr(input logic [31:0] addr,
                                            input int unsigned ram_aw);
        logic [31:0] wa;
        wa = {addr[31:2], 2'b00};
        if ((wa >> (ram_aw + 2)) == 32'd0)          return REG_RAM;
        if (wa == MMIO_BASE + OFF_TOHOST)           return REG_TOHOST;
        if (wa == MMIO_BASE + OFF_CYCLE)            return REG_CYCLE;
        if (wa == MMIO_BASE + OFF_CONS_DATA)        return REG_CONS_DATA;
        if (wa == MMIO_BASE + OFF_CONS_STAT)        return REG_CONS_STAT;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Data-memory request/response bus.
//   dmem_en   : access request this cycle
//   dmem_addr : byte address (word aligned, bits [1:0] ignored)
//   dmem_d    : write data, lanes already positioned
//   dmem_we   : per-byte write enables, 0 = read
//   dmem_q    : registered read data
//   master drives the request, slave (the responder) returns dmem_q.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        dmem_en;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_d;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_q;

    modport master (output dmem_en, output dmem_addr, output dmem_d,
                    output dmem_we, input dmem_q);
    modport slave  (input dmem_en, input dmem_addr, input dmem_d,
                    input dmem_we, output dmem_q);
endinterface

// File: rtl/dmem_responder_byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
//   Byte-wide synchronous FIFO for the console path.
//   clk, rst_n : clock, async active-low reset (pointers/count only)
//   push       : write push_data when not full, or when full with a pop
//   push_data  : byte to write
//   pop        : remove head byte (ignored when empty)
//   head       : byte at the head, 0 when empty
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    storage [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a byte when a slot frees up in the same cycle.
    assign do_push = push && (!full || do_pop);
    // Storage is not reset, so mask the head to keep it clean while empty.
    assign head    = empty ? 8'h00 : storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

    // Power-of-two depth: pointers wrap modulo DEPTH by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Simulation/FPGA data-memory responder: word RAM plus a small MMIO block
//   (TOHOST, CYCLE counter, console FIFO).
//   clk, rst_n   : clock, async active-low reset
//   bus          : dmem_responder_if.slave request/response bus
//   tohost_valid : TOHOST written since reset (sticky)
//   tohost_data  : last merged TOHOST value
//   cons_valid   : console byte available
//   cons_data    : console byte at FIFO head
//   cons_ready   : sink accepts the byte when high with cons_valid
//   Build option: DMEM_RESPONDER_CONSOLE_EN adds the console FIFO with its
//   CONS_DATA/CONS_STAT registers; without it those addresses are unmapped
//   and cons_valid/cons_data are tied low.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_WORDS  = 4096,
    parameter int CONS_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_responder_if.slave        bus,
    output logic                   tohost_valid,
    output logic [31:0]            tohost_data,
    output logic                   cons_valid,
    output logic [7:0]             cons_data,
    input  logic                   cons_ready
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] widx;
    region_t       region;
    logic          wr;
    logic [31:0]   cycle_cnt;
    logic [31:0]   cons_stat;
    logic [31:0]   rdata;

    assign widx = bus.dmem_addr[AW+1:2];
    assign wr   = bus.dmem_en && (bus.dmem_we != 4'b0000);

    always_comb begin
        region = decode_addr(bus.dmem_addr, AW);
`ifndef DMEM_RESPONDER_CONSOLE_EN
        if (region == REG_CONS_DATA || region == REG_CONS_STAT) region = REG_NONE;
`endif
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (wr && region == REG_RAM) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.dmem_we[b]) mem[widx][8*b +: 8] <= bus.dmem_d[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cycle_cnt <= 32'd0;
        else        cycle_cnt <= cycle_cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tohost_valid <= 1'b0;
            tohost_data  <= 32'd0;
        end else if (wr && region == REG_TOHOST) begin
            tohost_valid <= 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (bus.dmem_we[b]) tohost_data[8*b +: 8] <= bus.dmem_d[8*b +: 8];
            end
        end
    end

`ifdef DMEM_RESPONDER_CONSOLE_EN
    localparam int CW = $clog2(CONS_DEPTH) + 1;

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    assign push = wr && (region == REG_CONS_DATA) && bus.dmem_we[0];
    assign pop  = cons_valid && cons_ready;

    byte_fifo #(.DEPTH(CONS_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.dmem_d[7:0]),
        .pop       (pop),
        .head      (cons_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // cons_* come only from FIFO registers; no path from the request bus.
    assign cons_valid = !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end

    assign cons_stat = {overflow, 23'd0, 8'(count)};
`else
    logic unused_cons;

    assign unused_cons = cons_ready;
    assign cons_valid  = 1'b0;
    assign cons_data   = 8'h00;
    assign cons_stat   = 32'd0;
`endif

    // Read mux sees pre-edge state, so a write returns the old word.
    always_comb begin
        rdata = 32'd0;
        case (region)
            REG_RAM:       rdata = mem[widx];
            REG_TOHOST:    rdata = tohost_data;
            REG_CYCLE:     rdata = cycle_cnt;
            REG_CONS_STAT: rdata = cons_stat;
            default:       rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           bus.dmem_q <= 32'd0;
        else if (bus.dmem_en) bus.dmem_q <= rdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder: RAM byte lanes, read-before-write,
//   unmapped space, TOHOST, CYCLE counter and wrap, console FIFO and reset.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
    logic        clk;
    logic        rst_n;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_TOHOST = 32'h8000_0000;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
    localparam logic [31:0] A_CDATA  = 32'h8000_0008;
    localparam logic [31:0] A_CSTAT  = 32'h8000_000C;

    dmem_responder_if bus ();

    dmem_responder #(.MEM_WORDS(4096), .CONS_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
        .cons_valid   (cons_valid),
        .cons_data    (cons_data),
        .cons_ready   (cons_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access cycle starting at a falling edge; returns at the next falling
    // edge with the response already in dmem_q.
    task automatic acc(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] w);
        bus.dmem_en   = 1'b1;
        bus.dmem_addr = a;
        bus.dmem_d    = dat;
        bus.dmem_we   = w;
        @(negedge clk);
        bus.dmem_en   = 1'b0;
        bus.dmem_we   = 4'b0000;
    endtask

    logic [31:0] c1;
    logic [31:0] c2;

    initial begin
        rst_n         = 1'b0;
        cons_ready    = 1'b0;
        bus.dmem_en   = 1'b0;
        bus.dmem_addr = 32'd0;
        bus.dmem_d    = 32'd0;
        bus.dmem_we   = 4'b0000;
        repeat (2) @(negedge clk);

        check("rst_q",            bus.dmem_q,           32'd0);
        check("rst_tohost_valid", 32'(tohost_valid),    32'd0);
        check("rst_tohost_data",  tohost_data,          32'd0);
        check("rst_cons_valid",   32'(cons_valid),      32'd0);
        check("rst_cons_data",    32'(cons_data),       32'd0);

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("q_idle_after_rst", bus.dmem_q, 32'd0);

        // RAM full word, hold, lane merge with read-before-write
        acc(32'h10, 32'hDEAD_BEEF, 4'b1111);
        acc(32'h10, 32'h0, 4'b0000);
        check("ram_read_full", bus.dmem_q, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        check("q_hold_idle", bus.dmem_q, 32'hDEAD_BEEF);
        acc(32'h10, 32'h0000_00AA, 4'b0001);
        check("ram_rbw", bus.dmem_q, 32'hDEAD_BEEF);
        acc(32'h10, 32'h0, 4'b0000);
        check("ram_lane0", bus.dmem_q, 32'hDEAD_BEAA);
        acc(32'h13, 32'h0, 4'b0000);
        check("ram_low_bits_ignored", bus.dmem_q, 32'hDEAD_BEAA);

        // Unmapped space
        acc(32'h4000_0000, 32'h0, 4'b0000);
        check("unmapped_read", bus.dmem_q, 32'd0);
        acc(32'h4000_0010, 32'h1234_5678, 4'b1111);
        acc(32'h10, 32'h0, 4'b0000);
        check("unmapped_write_no_alias", bus.dmem_q, 32'hDEAD_BEAA);
        acc(32'h4000_0010, 32'h0, 4'b0000);
        check("unmapped_write_ignored", bus.dmem_q, 32'd0);

        // TOHOST
        check("tohost_valid_before", 32'(tohost_valid), 32'd0);
        acc(A_TOHOST, 32'h1, 4'b1111);
        check("tohost_valid", 32'(tohost_valid), 32'd1);
        check("tohost_data",  tohost_data,       32'd1);
        acc(A_TOHOST, 32'hAB00_0000, 4'b1000);
        check("tohost_rbw",        bus.dmem_q,  32'd1);
        check("tohost_lane_merge", tohost_data, 32'hAB00_0001);
        acc(A_TOHOST, 32'h0, 4'b0000);
        check("tohost_read", bus.dmem_q, 32'hAB00_0001);

        // CYCLE: two reads 10 cycles apart
        acc(A_CYCLE, 32'h0, 4'b0000);
        c1 = bus.dmem_q;
        repeat (9) @(negedge clk);
        acc(A_CYCLE, 32'h0, 4'b0000);
        c2 = bus.dmem_q;
        check("cycle_delta10", c2 - c1, 32'd10);

        // CYCLE wrap from a forced value
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_cnt;
        bus.dmem_en   = 1'b1;
        bus.dmem_addr = A_CYCLE;
        bus.dmem_we   = 4'b0000;
        @(negedge clk);
        check("cycle_pre_wrap0", bus.dmem_q, 32'hFFFF_FFFE);
        @(negedge clk);
        check("cycle_pre_wrap1", bus.dmem_q, 32'hFFFF_FFFF);
        @(negedge clk);
        check("cycle_wrap_zero", bus.dmem_q, 32'd0);
        bus.dmem_en = 1'b0;

        // Writes to CYCLE are ignored: back-to-back accesses differ by one
        acc(A_CYCLE, 32'h0, 4'b1111);
        c1 = bus.dmem_q;
        acc(A_CYCLE, 32'h0, 4'b0000);
        c2 = bus.dmem_q;
        check("cycle_write_ignored", c2 - c1, 32'd1);

`ifdef DMEM_RESPONDER_CONSOLE_EN
        check("cons_empty", 32'(cons_valid), 32'd0);
        acc(A_CDATA, 32'h41, 4'b0001);
        check("cons_valid_next_cycle", 32'(cons_valid), 32'd1);
        check("cons_head_first",       32'(cons_data),  32'h41);
        for (int i = 1; i < 5; i++) acc(A_CDATA, 32'h41 + 32'(i), 4'b0001);
        acc(A_CSTAT, 32'h0, 4'b0000);
        check("cons_stat_overflow", bus.dmem_q, 32'h8000_0004);

        cons_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(cons_valid), 32'd1);
            check("drain_data",  32'(cons_data),  32'h41 + 32'(i));
            @(negedge clk);
        end
        check("drain_empty", 32'(cons_valid), 32'd0);
        cons_ready = 1'b0;
        acc(A_CSTAT, 32'h0, 4'b0000);
        check("cons_stat_sticky", bus.dmem_q, 32'h8000_0000);

        // Fill, then push into the full FIFO with a simultaneous pop
        for (int i = 0; i < 4; i++) acc(A_CDATA, 32'h50 + 32'(i), 4'b0001);
        cons_ready = 1'b1;
        acc(A_CDATA, 32'h54, 4'b0001);
        cons_ready = 1'b0;
        check("full_push_pop_head", 32'(cons_data), 32'h51);
        acc(A_CSTAT, 32'h0, 4'b0000);
        check("full_push_pop_count", bus.dmem_q, 32'h8000_0004);

        // Reset in the middle of a drain
        cons_ready = 1'b1;
        @(negedge clk);
        check("mid_drain_head", 32'(cons_data), 32'h52);
`else
        acc(A_CDATA, 32'h41, 4'b0001);
        check("cons_disabled_valid", 32'(cons_valid), 32'd0);
        check("cons_disabled_data",  32'(cons_data),  32'd0);
        acc(A_CSTAT, 32'h0, 4'b0000);
        check("cons_stat_unmapped", bus.dmem_q, 32'd0);
        cons_ready = 1'b1;
        @(negedge clk);
`endif
        rst_n = 1'b0;
        #1;
        check("rst_async_cons_valid",   32'(cons_valid),   32'd0);
        check("rst_async_cons_data",    32'(cons_data),    32'd0);
        check("rst_async_tohost_valid", 32'(tohost_valid), 32'd0);
        check("rst_async_q",            bus.dmem_q,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cons_ready = 1'b0;
        @(negedge clk);
        acc(A_CSTAT, 32'h0, 4'b0000);
        check("cons_stat_after_rst", bus.dmem_q, 32'd0);
        check("tohost_after_rst", 32'(tohost_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, RAM size in 32-bit words (power of two).
REQ-002 SHALL have parameter CONS_DEPTH, default 4, console FIFO entries (power of two, 2..16).
REQ-003 SHALL have ports:
  - clk  in  1  single clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - dmem_en  in  1  access request this cycle.
  - dmem_addr  in  32  word-aligned byte address; bits[1:0] ignored.
  - dmem_d  in  32  write data, byte lanes already positioned.
  - dmem_we  in  4  per-byte write enables; 0 means read.
  - dmem_q  out  32  read data.
  - tohost_valid  out  1  tohost register written since reset.
  - tohost_data  out  32  last value written to tohost.
  - cons_valid  out  1  console byte available.
  - cons_data  out  8  console byte at FIFO head.
  - cons_ready  in  1  sink accepts byte when high with cons_valid.

Function
REQ-004 SHALL decode the address map:
  - RAM at 0x0000_0000..4*MEM_WORDS-1.
  - TOHOST at 0x8000_0000 (R/W).
  - CYCLE at 0x8000_0004 (R).
  - CONS_DATA at 0x8000_0008 (W).
  - CONS_STAT at 0x8000_000C (R).
  - All other addresses unmapped.
REQ-005 SHALL perform the write on the rising edge where dmem_en=1 and dmem_we!=0, updating only the enabled byte lanes.
REQ-006 SHALL return read data on dmem_q exactly one cycle after the dmem_en=1 cycle (registered output).
REQ-007 SHALL hold dmem_q unchanged in cycles that follow dmem_en=0.
REQ-008 SHALL, for a write access, load dmem_q the next cycle with the pre-write contents of the addressed word (read-before-write).
REQ-009 SHALL return 0 for unmapped reads and ignore unmapped writes.
REQ-010 SHALL keep a 32-bit free-running CYCLE counter: increments every clock, wraps 0xFFFF_FFFF->0, ignores writes.
REQ-011 SHALL, on any TOHOST write, merge the enabled lanes into tohost_data and set tohost_valid=1 (sticky until reset).
REQ-012 SHALL, on a CONS_DATA write with dmem_we[0]=1, push dmem_d[7:0] into the console FIFO.
REQ-013 SHALL, on a push while the FIFO is full with no pop in the same cycle, drop the byte and set the sticky overflow flag.
REQ-014 SHALL accept a push into a full FIFO when a pop occurs in the same cycle; count stays unchanged.
REQ-015 SHALL drive cons_valid=1 whenever the FIFO is non-empty, with cons_data the head byte; pop when cons_valid && cons_ready.
REQ-016 SHALL make a byte pushed into an empty FIFO visible on cons_valid the following cycle, with no combinational path from dmem_* to cons_*.
REQ-017 SHALL read CONS_STAT as {overflow[31], 23'b0, count[7:0]}, where count is the current FIFO occupancy.
REQ-018 SHALL wrap FIFO pointers modulo CONS_DEPTH.

Reset
REQ-019 SHALL, while rst_n=0, force: dmem_q=0, tohost_valid=0, tohost_data=0, CYCLE=0, FIFO empty, overflow=0, cons_valid=0, cons_data=0.
REQ-020 SHALL leave RAM contents undefined (not cleared) by reset.
REQ-021 SHALL abandon any access in flight at reset assertion; the first post-reset dmem_q update follows the first dmem_en=1 cycle.

Configuration
REQ-022 SHALL, when macro DMEM_RESPONDER_CONSOLE_EN is defined, include the console FIFO, CONS_DATA and CONS_STAT.
REQ-023 SHALL, when DMEM_RESPONDER_CONSOLE_EN is undefined:
  - tie cons_valid=0 and cons_data=0;
  - treat CONS_DATA and CONS_STAT as unmapped.

Structure
REQ-024 SHALL place the MMIO base address and register offsets in the shared defines file, alongside the existing opcode/funct constants.
REQ-025 SHALL implement the console FIFO as sub-module byte_fifo, with ports: push, push_data, pop, head, count, full, empty.

Verification
REQ-026 SHALL cover: write 0xDEADBEEF to 0x10 with we=1111, read 0x10 -> dmem_q=0xDEADBEEF one cycle after the read request.
REQ-027 SHALL cover: write 0x000000AA with we=0001 to 0x10, then read -> 0xDEADBEAA; a read of 0x4000_0000 -> 0.
REQ-028 SHALL cover: write 0x1 to 0x8000_0000 -> tohost_valid=1 and tohost_data=1 next cycle.
REQ-029 SHALL cover: two CYCLE reads 10 cycles apart -> values differ by 10; counter forced near 0xFFFF_FFFF -> wraps to 0.
REQ-030 SHALL cover, with cons_ready=0, five pushes 0x41..0x45 at CONS_DEPTH=4:
  - CONS_STAT reads 0x8000_0004;
  - after raising cons_ready, bytes 0x41..0x44 drain in order.
REQ-031 SHALL cover: reset asserted mid-drain -> cons_valid=0 and CONS_STAT=0 immediately, tohost_valid=0.
